// File: rtl/parity_seq_gen.sv
// Purpose: emits COUNT values of one parity (odd/even) starting at the first value >= BASE of that parity, stepping by 2.
// Latency: first value is valid the cycle after start; back-to-back transfers sustain one value per cycle.
// Backpressure: while out_valid && !out_ready the current value is held; out_valid only drops after a transfer.
module parity_seq_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             want_odd,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_odd,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] first_d;
  logic             xfer;

  // First value of the run: base itself if its parity matches, otherwise the next number (wraps at 2^WIDTH).
  always_comb begin
    first_d = base;
    if (base[0] != want_odd) begin
      first_d = base + WIDTH'(1);
    end
  end

  assign xfer = valid_q && out_ready;

  // Sequencer: IDLE -> RUN -> DONE -> IDLE, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (count != '0) begin
              // Parity is fixed by the first value; stepping by 2 preserves it, so want_odd need not be kept.
              remaining_q <= count;
              data_q      <= first_d;
              valid_q     <= 1'b1;
              state_q     <= S_RUN;
            end else begin
              // Empty run: report completion without ever raising out_valid.
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            remaining_q <= remaining_q - WIDTH'(1);
            if (remaining_q == WIDTH'(1)) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              data_q <= data_q + WIDTH'(2);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_odd   = data_q[0];
  assign done      = done_q;

endmodule
